// File: rtl/fifo_pkt_writer.sv
// fifo_pkt_writer
// Write-side packetizer for the dual-clock FIFO (wr_clk domain). It collects one byte-stream
// packet from a valid/ready source into local storage, then writes a one-byte length header
// {trunc, len[6:0]} followed by the stored payload into the FIFO. Packets longer than MAX_LEN
// keep their first MAX_LEN bytes, the remainder is dropped and the header trunc bit is set.
//
// Ports:
//   wr_clk     clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   source byte valid
//   in_data    source byte
//   in_last    final byte of packet, qualified by in_valid
//   in_ready   byte accepted on an edge where in_valid & in_ready
//   full       FIFO full flag
//   wr_en      FIFO write strobe (never asserted while full)
//   wdata      FIFO write data
//   busy       header or payload write in progress
//   pkt_cnt    packets fully written to the FIFO, wrapping
//   trunc_cnt  truncated packets, saturating at 0xFF
module fifo_pkt_writer #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        wr_clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        full,
  output logic        wr_en,
  output logic [7:0]  wdata,
  output logic        busy,
  output logic [15:0] pkt_cnt,
  output logic [7:0]  trunc_cnt
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] MaxLen = CNT_W'(MAX_LEN);

  localparam logic [1:0] StCollect = 2'd0;
  localparam logic [1:0] StDiscard = 2'd1;
  localparam logic [1:0] StHdr     = 2'd2;
  localparam logic [1:0] StPayload = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
  logic             trunc_q, trunc_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;
  logic [7:0]       trunc_cnt_q, trunc_cnt_d;
  logic [7:0]       mem [MAX_LEN];

  logic             accept;
  logic [CNT_W-1:0] len_inc;
  logic [CNT_W-1:0] rd_inc;
  logic [7:0]       hdr_byte;
  logic [7:0]       rd_data;

  // Outputs are gated by rst so nothing leaks to the FIFO on a reset edge mid-packet.
  assign in_ready = ~rst & ((state_q == StCollect) | (state_q == StDiscard));
  assign busy     = ~rst & ((state_q == StHdr) | (state_q == StPayload));
  assign wr_en    = busy & ~full;
  assign accept   = in_valid & in_ready;

  assign len_inc  = len_q + CNT_W'(1);
  assign rd_inc   = rd_idx_q + CNT_W'(1);
  assign hdr_byte = {trunc_q, 7'(len_q)};
  assign rd_data  = mem[rd_idx_q[IDX_W-1:0]];

  assign pkt_cnt   = pkt_cnt_q;
  assign trunc_cnt = trunc_cnt_q;

  always_comb begin
    wdata = 8'h00;
    if (!rst) begin
      if (state_q == StHdr) begin
        wdata = hdr_byte;
      end else if (state_q == StPayload) begin
        wdata = rd_data;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_idx_d    = rd_idx_q;
    trunc_d     = trunc_q;
    pkt_cnt_d   = pkt_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    unique case (state_q)
      StCollect: begin
        if (accept) begin
          len_d = len_inc;
          if (in_last) begin
            state_d = StHdr;
            trunc_d = 1'b0;
          end else if (len_inc == MaxLen) begin
            state_d = StDiscard;
            trunc_d = 1'b1;
          end
        end
      end
      StDiscard: begin
        if (accept && in_last) begin
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (wr_en) begin
          state_d  = StPayload;
          rd_idx_d = '0;
        end
      end
      StPayload: begin
        if (wr_en) begin
          rd_idx_d = rd_inc;
          // rd_inc == len marks the write of the last stored byte.
          if (rd_inc == len_q) begin
            state_d   = StCollect;
            len_d     = '0;
            trunc_d   = 1'b0;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            if (trunc_q && (trunc_cnt_q != 8'hFF)) begin
              trunc_cnt_d = trunc_cnt_q + 8'd1;
            end
          end
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q     <= StCollect;
      len_q       <= '0;
      rd_idx_q    <= '0;
      trunc_q     <= 1'b0;
      pkt_cnt_q   <= '0;
      trunc_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rd_idx_q    <= rd_idx_d;
      trunc_q     <= trunc_d;
      pkt_cnt_q   <= pkt_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  // Payload store has no reset; only entries below len are ever read.
  always_ff @(posedge wr_clk) begin
    if (accept && (state_q == StCollect)) begin
      mem[len_q[IDX_W-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Bench for fifo_pkt_writer: directed packets with literal expectations plus 300 random
// packets under random full, checked every cycle against a queue of expected FIFO bytes.
module tb_fifo_pkt_writer;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 5;

  logic        wr_clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        full = 1'b0;
  logic        wr_en;
  logic [7:0]  wdata;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic [7:0]  trunc_cnt;

  fifo_pkt_writer #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .wr_clk   (wr_clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .full     (full),
    .wr_en    (wr_en),
    .wdata    (wdata),
    .busy     (busy),
    .pkt_cnt  (pkt_cnt),
    .trunc_cnt(trunc_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  bit          rand_full = 1'b0;
  int unsigned cyc = 0;
  int unsigned last_acc_cyc = 0;

  // Expected FIFO stream: {last_of_packet, trunc, byte}.
  logic [9:0]  exp_q[$];
  logic [7:0]  log_q[$];
  int unsigned log_cyc[$];
  logic [7:0]  cur_pkt[$];
  logic [15:0] m_pkt = 16'd0;
  logic [7:0]  m_trunc = 8'd0;

  always @(posedge wr_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Per-cycle comparison against the expected stream.
  always @(negedge wr_clk) begin
    if (rst) begin
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wdata", 32'(wdata), 32'd0);
      exp_q.delete();
      m_pkt = 16'd0;
      m_trunc = 8'd0;
    end else begin
      check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
      check("busy", 32'(busy), 32'(exp_q.size() != 0));
      check("wr_en", 32'(wr_en), 32'((exp_q.size() != 0) && !full));
      check("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
      check("trunc_cnt", 32'(trunc_cnt), 32'(m_trunc));
      if (exp_q.size() != 0) begin
        check("wdata", 32'(wdata), 32'(exp_q[0][7:0]));
        if (wr_en) begin
          logic [9:0] e;
          e = exp_q.pop_front();
          log_q.push_back(wdata);
          log_cyc.push_back(cyc + 1);
          if (e[9]) begin
            m_pkt = m_pkt + 16'd1;
            if (e[8] && (m_trunc != 8'hFF)) m_trunc = m_trunc + 8'd1;
          end
        end
      end
    end
  end

  // Turn a completed source packet into its FIFO byte sequence.
  task automatic finish_pkt();
    int  n;
    int  stored;
    bit  tr;
    n = cur_pkt.size();
    tr = (n > MAX_LEN);
    stored = tr ? MAX_LEN : n;
    exp_q.push_back({1'b0, tr, tr, 7'(stored)});
    for (int i = 0; i < stored; i++) exp_q.push_back({(i == stored - 1), tr, cur_pkt[i]});
    cur_pkt.delete();
  endtask

  task automatic step(output bit acc);
    bit r;
    @(negedge wr_clk);
    acc = in_valid & in_ready;
    r = rst;
    @(posedge wr_clk);
    #1;
    if (r) begin
      cur_pkt.delete();
      acc = 1'b0;
    end else if (acc) begin
      cur_pkt.push_back(in_data);
      last_acc_cyc = cyc;
      if (in_last) finish_pkt();
    end
    if (rand_full) full = ($urandom_range(0, 2) == 0);
  endtask

  task automatic send_pkt(input logic [7:0] bytes[$], input bit gaps, output int steps);
    bit a;
    int b;
    steps = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      in_valid = 1'b1;
      in_data = bytes[i];
      in_last = (i == bytes.size() - 1);
      b = 0;
      do begin
        step(a);
        b++;
        steps++;
      end while (!a && b < 500);
      if (!a) check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      in_last = 1'b0;
      if (gaps && ($urandom_range(0, 3) == 0)) step(a);
    end
  endtask

  task automatic wait_idle();
    bit a;
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 2000) begin
      step(a);
      b++;
    end
    if (exp_q.size() != 0) check("idle_timeout", 32'(exp_q.size()), 32'd0);
    step(a);
  endtask

  task automatic do_reset();
    bit a;
    rst = 1'b1;
    step(a);
    step(a);
    rst = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pk[$];
    int base;
    int steps;
    int b;
    bit a;
    int hdr_acc;

    do_reset();
    check("reset_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("reset_trunc_cnt", 32'(trunc_cnt), 32'd0);

    // Basic packet
    base = log_q.size();
    pk = '{8'hA1, 8'hB2, 8'hC3};
    send_pkt(pk, 1'b0, steps);
    hdr_acc = last_acc_cyc;
    wait_idle();
    check("basic_len", 32'(log_q.size() - base), 32'd4);
    check("basic_hdr", 32'(log_q[base]), 32'h03);
    check("basic_b0", 32'(log_q[base+1]), 32'hA1);
    check("basic_b1", 32'(log_q[base+2]), 32'hB2);
    check("basic_b2", 32'(log_q[base+3]), 32'hC3);
    check("basic_hdr_edge", log_cyc[base], hdr_acc + 1);
    check("basic_consec", log_cyc[base+3], log_cyc[base] + 3);
    check("basic_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Truncation
    base = log_q.size();
    pk.delete();
    for (int i = 0; i < 20; i++) pk.push_back(8'(i));
    send_pkt(pk, 1'b0, steps);
    check("trunc_ready_steps", 32'(steps), 32'd20);
    wait_idle();
    check("trunc_len", 32'(log_q.size() - base), 32'd17);
    check("trunc_hdr", 32'(log_q[base]), 32'h90);
    check("trunc_first", 32'(log_q[base+1]), 32'h00);
    check("trunc_lastb", 32'(log_q[base+16]), 32'h0F);
    check("trunc_cnt1", 32'(trunc_cnt), 32'd1);

    // Backpressure
    base = log_q.size();
    pk = '{8'h55, 8'h66};
    send_pkt(pk, 1'b0, steps);
    full = 1'b1;
    repeat (5) step(a);
    full = 1'b0;
    step(a);
    step(a);
    check("bp_mid_len", 32'(log_q.size() - base), 32'd2);
    full = 1'b1;
    repeat (3) step(a);
    full = 1'b0;
    wait_idle();
    check("bp_len", 32'(log_q.size() - base), 32'd3);
    check("bp_hdr", 32'(log_q[base]), 32'h02);
    check("bp_b0", 32'(log_q[base+1]), 32'h55);
    check("bp_b1", 32'(log_q[base+2]), 32'h66);
    check("bp_pkt_cnt", 32'(pkt_cnt), 32'd3);

    // Exact-length end
    base = log_q.size();
    pk.delete();
    for (int i = 0; i < 16; i++) pk.push_back(8'(8'h20 + i));
    send_pkt(pk, 1'b0, steps);
    wait_idle();
    check("exact_len", 32'(log_q.size() - base), 32'd17);
    check("exact_hdr", 32'(log_q[base]), 32'h10);
    check("exact_lastb", 32'(log_q[base+16]), 32'h2F);
    check("exact_trunc_cnt", 32'(trunc_cnt), 32'd1);

    // Reset mid-operation
    do_reset();
    base = log_q.size();
    pk = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(pk, 1'b0, steps);
    b = 0;
    while (log_q.size() < base + 2 && b < 100) begin
      step(a);
      b++;
    end
    check("rmid_reached", 32'(log_q.size() - base), 32'd2);
    rst = 1'b1;
    step(a);
    rst = 1'b0;
    repeat (4) step(a);
    check("rmid_no_writes", 32'(log_q.size() - base), 32'd2);
    check("rmid_pkt_cnt", 32'(pkt_cnt), 32'd0);
    pk = '{8'h7E};
    send_pkt(pk, 1'b0, steps);
    wait_idle();
    check("rmid_new_len", 32'(log_q.size() - base), 32'd4);
    check("rmid_new_hdr", 32'(log_q[base+2]), 32'h01);
    check("rmid_new_b0", 32'(log_q[base+3]), 32'h7E);
    check("rmid_new_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Back-to-back random packets under random full
    do_reset();
    rand_full = 1'b1;
    for (int p = 0; p < 300; p++) begin
      int n;
      n = $urandom_range(1, MAX_LEN);
      pk.delete();
      for (int i = 0; i < n; i++) pk.push_back(8'($urandom));
      send_pkt(pk, 1'b1, steps);
    end
    rand_full = 1'b0;
    full = 1'b0;
    wait_idle();
    check("rand_pkt_cnt", 32'(pkt_cnt), 32'd300);
    check("rand_trunc_cnt", 32'(trunc_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
